// File: rtl/sys_arr_tile_ctrl.sv
// Handshake sequencer for an NxN systolic-array tile: clears accumulators, streams
// k_len operands per edge lane with a one-cycle-per-lane skew, then waits on the corner PE.

module sys_arr_lane #(
  parameter int KW = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic [KW-1:0] i_k_len,
  input  logic          i_src_valid,
  input  logic          i_edge_ready,
  output logic          o_valid,
  output logic          o_pop,
  output logic          o_full_nxt
);
  logic [KW-1:0] r_cnt;

  // Valid never looks at ready; the count can only reach k_len, never pass it.
  assign o_valid    = i_en && (r_cnt < i_k_len) && i_src_valid;
  assign o_pop      = o_valid && i_edge_ready;
  assign o_full_nxt = ((r_cnt + KW'(o_pop)) == i_k_len);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)      r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (o_pop) r_cnt <= r_cnt + 1'b1;
  end
endmodule

module sys_arr_tile_ctrl #(
  parameter int N  = 4,
  parameter int KW = 16
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic           i_abort,
  input  logic [KW-1:0]  i_k_len,
  input  logic [N-1:0]   i_a_src_valid,
  output logic [N-1:0]   o_a_src_pop,
  output logic [N-1:0]   o_row_edge_valid,
  input  logic [N-1:0]   i_row_edge_ready,
  input  logic [N-1:0]   i_b_src_valid,
  output logic [N-1:0]   o_b_src_pop,
  output logic [N-1:0]   o_col_edge_valid,
  input  logic [N-1:0]   i_col_edge_ready,
  input  logic           i_corner_done,
  input  logic [N*N-1:0] i_pe_err,
  output logic           o_acc_clr,
  output logic           o_busy,
  output logic           o_done,
  output logic           o_err
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [KW-1:0]       r_k_len, r_dcnt;
  logic [SW-1:0]       r_skew;
  logic                r_err;
  logic                w_accept, w_feed, w_track;
  logic [1:0][N-1:0]   w_src, w_rdy, w_vld, w_pop, w_full;

  // Side 0 = west-edge rows, side 1 = north-edge columns.
  assign w_src = {i_b_src_valid, i_a_src_valid};
  assign w_rdy = {i_col_edge_ready, i_row_edge_ready};

  assign w_accept = (r_state == S_IDLE) && i_start;
  assign w_feed   = (r_state == S_FEED);
  assign w_track  = (r_state == S_FEED) || (r_state == S_DRAIN);

  for (genvar g = 0; g < 2; g++) begin : g_side
    for (genvar i = 0; i < N; i++) begin : g_lane
      sys_arr_lane #(.KW(KW)) u_lane (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_clr        (w_accept),
        .i_en         (w_feed && (r_skew >= SW'(i))),
        .i_k_len      (r_k_len),
        .i_src_valid  (w_src[g][i]),
        .i_edge_ready (w_rdy[g][i]),
        .o_valid      (w_vld[g][i]),
        .o_pop        (w_pop[g][i]),
        .o_full_nxt   (w_full[g][i])
      );
    end
  end

  assign o_row_edge_valid = w_vld[0];
  assign o_col_edge_valid = w_vld[1];
  assign o_a_src_pop      = w_pop[0];
  assign o_b_src_pop      = w_pop[1];
  assign o_err            = r_err;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_acc_clr   = 1'b0;
    o_busy      = 1'b1;
    o_done      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start) w_state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        o_acc_clr   = 1'b1;
        w_state_nxt = (r_k_len == '0) ? S_DONE : S_FEED;
      end
      // Exit on the cycle the last handshake lands, using next-cycle lane counts.
      S_FEED:  if (&w_full) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_dcnt >= r_k_len) w_state_nxt = S_DONE;
      S_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (i_abort && (r_state != S_IDLE)) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_k_len <= '0;
      r_skew  <= '0;
      r_dcnt  <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_k_len <= i_k_len;
      r_skew  <= '0;
      r_dcnt  <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_feed && (r_skew != SW'(N-1))) r_skew <= r_skew + 1'b1;
      if (w_track) begin
        if (i_corner_done && (r_dcnt != '1)) r_dcnt <= r_dcnt + 1'b1;
        r_err <= r_err | (|i_pe_err);
      end
    end
  end
endmodule

// File: tb/tb_sys_arr_tile_ctrl.sv
// Bench for sys_arr_tile_ctrl: per-cycle behavioural model compare plus hand-computed tile timelines.
module tb_sys_arr_tile_ctrl;
  localparam int N  = 4;
  localparam int KW = 16;
  localparam int NL = 2 * N;
  localparam int P_IDLE = 0, P_CLEAR = 1, P_FEED = 2, P_DRAIN = 3, P_DONE = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           i_start, i_abort, i_corner_done;
  logic [KW-1:0]  i_k_len;
  logic [N-1:0]   i_a_src_valid, i_b_src_valid, i_row_edge_ready, i_col_edge_ready;
  logic [N-1:0]   o_a_src_pop, o_b_src_pop, o_row_edge_valid, o_col_edge_valid;
  logic [N*N-1:0] i_pe_err;
  logic           o_acc_clr, o_busy, o_done, o_err;

  always #5 clk = ~clk;

  sys_arr_tile_ctrl #(.N(N), .KW(KW)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_abort(i_abort), .i_k_len(i_k_len),
    .i_a_src_valid(i_a_src_valid), .o_a_src_pop(o_a_src_pop),
    .o_row_edge_valid(o_row_edge_valid), .i_row_edge_ready(i_row_edge_ready),
    .i_b_src_valid(i_b_src_valid), .o_b_src_pop(o_b_src_pop),
    .o_col_edge_valid(o_col_edge_valid), .i_col_edge_ready(i_col_edge_ready),
    .i_corner_done(i_corner_done), .i_pe_err(i_pe_err),
    .o_acc_clr(o_acc_clr), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Model: tile phase, captured length, handshakes per lane, cycles spent feeding,
  // corner completions and error flag.
  int   ph = P_IDLE, mk = 0, mfc = 0, mdc = 0, tcyc = 0;
  bit   merr = 1'b0;
  int   mcnt [NL];
  int   pops [NL];
  logic [63:0] h_clr, h_rv0, h_rv3, h_done, h_anyv;

  always @(negedge clk) begin
    logic [NL-1:0] src, rdy, e_v, e_p;
    int nph;
    bit allf;
    src = {i_b_src_valid, i_a_src_valid};
    rdy = {i_col_edge_ready, i_row_edge_ready};
    if (rst) begin
      ph = P_IDLE; mk = 0; mfc = 0; mdc = 0; merr = 1'b0;
      for (int l = 0; l < NL; l++) mcnt[l] = 0;
    end
    // Lane l (position l mod N) may present once it has been feeding that many cycles.
    for (int l = 0; l < NL; l++) begin
      e_v[l] = (ph == P_FEED) && (mfc >= (l % N)) && (mcnt[l] < mk) && src[l];
      e_p[l] = e_v[l] && rdy[l];
    end
    chk("busy", o_busy, ph != P_IDLE);
    chk("acc_clr", o_acc_clr, ph == P_CLEAR);
    chk("done", o_done, ph == P_DONE);
    chk("err", o_err, merr);
    chk("row_valid", o_row_edge_valid, e_v[N-1:0]);
    chk("col_valid", o_col_edge_valid, e_v[NL-1:N]);
    chk("a_pop", o_a_src_pop, e_p[N-1:0]);
    chk("b_pop", o_b_src_pop, e_p[NL-1:N]);
    if (!rst) begin
      if (ph == P_IDLE && i_start) begin
        tcyc = 0;
        h_clr = '0; h_rv0 = '0; h_rv3 = '0; h_done = '0; h_anyv = '0;
        for (int l = 0; l < NL; l++) pops[l] = 0;
      end else tcyc++;
      if (tcyc < 64) begin
        h_clr[tcyc]  = o_acc_clr;
        h_rv0[tcyc]  = o_row_edge_valid[0];
        h_rv3[tcyc]  = o_row_edge_valid[3];
        h_done[tcyc] = o_done;
        h_anyv[tcyc] = |{o_row_edge_valid, o_col_edge_valid};
      end
      for (int l = 0; l < NL; l++)
        pops[l] += int'(l < N ? o_a_src_pop[l % N] : o_b_src_pop[l % N]);
      if (ph == P_DONE)
        for (int l = 0; l < NL; l++) chk("lane_pops", pops[l], mk);

      nph = ph;
      case (ph)
        P_IDLE: if (i_start) begin
          mk = int'(i_k_len); mfc = 0; mdc = 0; merr = 1'b0;
          for (int l = 0; l < NL; l++) mcnt[l] = 0;
          nph = P_CLEAR;
        end
        P_CLEAR: nph = (mk == 0) ? P_DONE : P_FEED;
        P_FEED: begin
          allf = 1'b1;
          for (int l = 0; l < NL; l++) begin
            mcnt[l] += int'(e_p[l]);
            if (mcnt[l] != mk) allf = 1'b0;
          end
          mfc++;
          if (allf) nph = P_DRAIN;
        end
        P_DRAIN: if (mdc >= mk) nph = P_DONE;
        P_DONE:  nph = P_IDLE;
        default: nph = P_IDLE;
      endcase
      if (ph == P_FEED || ph == P_DRAIN) begin
        if (i_corner_done && mdc < 65535) mdc++;
        if (|i_pe_err) merr = 1'b1;
      end
      if (ph != P_IDLE && i_abort) nph = P_IDLE;
      ph = nph;
    end
  end

  bit rnd_en = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rnd_en) begin
      i_a_src_valid    = N'($urandom);
      i_b_src_valid    = N'($urandom);
      i_row_edge_ready = N'($urandom);
      i_col_edge_ready = N'($urandom);
      i_corner_done    = ($urandom_range(0, 3) == 0);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic all_ones();
    i_a_src_valid = '1; i_b_src_valid = '1; i_row_edge_ready = '1; i_col_edge_ready = '1;
  endtask

  task automatic go(input int k);
    i_start = 1'b1; i_k_len = KW'(k);
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int t = 0;
    while (!o_done && t < budget) begin tick(); t++; end
    chk(nm, o_done, 1'b1);
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_k_len = '0; i_corner_done = 1'b0;
    i_pe_err = '0; all_ones();
    tick(3);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_outs", {o_acc_clr, o_done, o_err, o_row_edge_valid, o_col_edge_valid}, '0);
    rst = 1'b0;
    tick(2);

    // k=3, everything ready; corner completions in cycles 9..11.
    go(3);
    tick(8);
    i_corner_done = 1'b1; tick(3); i_corner_done = 1'b0;
    wait_done("t1_done", 50);
    chk("t1_err", o_err, 1'b0);
    tick();
    chk("t1_clr_cycles", h_clr[15:0], 16'h0002);
    chk("t1_rv0_cycles", h_rv0[15:0], 16'h001C);
    chk("t1_rv3_cycles", h_rv3[15:0], 16'h00E0);
    chk("t1_done_cycle", h_done[15:0], 16'h2000);
    tick(2);

    // k=0: CLEAR straight to DONE.
    go(0);
    wait_done("t2_done", 10);
    tick();
    chk("t2_done_cycle", h_done[7:0], 8'h04);
    chk("t2_no_valid", h_anyv[7:0], 8'h00);
    tick(2);

    // Random stalls on sources and readies.
    rnd_en = 1'b1;
    for (int t = 0; t < 5; t++) begin
      go(t == 0 ? 5 : $urandom_range(1, 8));
      wait_done("t3_done", 600);
      tick($urandom_range(1, 3));
    end
    rnd_en = 1'b0;
    tick();
    all_ones(); i_corner_done = 1'b0;
    tick(2);

    // Error pulse in FEED, then a clean tile.
    i_corner_done = 1'b1;
    go(3);
    tick(2);
    i_pe_err = 16'h0080; tick(); i_pe_err = '0;
    wait_done("t4_done", 50);
    chk("t4_err_set", o_err, 1'b1);
    tick(2);
    go(3);
    chk("t4_err_clr", o_err, 1'b0);
    wait_done("t4b_done", 50);
    chk("t4b_err", o_err, 1'b0);
    i_corner_done = 1'b0;
    tick(2);

    // Abort after two lane-0 handshakes, then a full tile.
    go(4);
    tick(3);
    i_abort = 1'b1; tick(); i_abort = 1'b0;
    chk("t5_abort_busy", o_busy, 1'b0);
    chk("t5_abort_valid", {o_row_edge_valid, o_col_edge_valid}, '0);
    tick(3);
    i_corner_done = 1'b1;
    go(3);
    wait_done("t5b_done", 50);
    i_corner_done = 1'b0;
    tick(2);

    // Reset during DRAIN, then a normal tile.
    go(2);
    tick(6);
    chk("t6_in_drain", o_busy, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_busy", o_busy, 1'b0);
    chk("t6_rst_outs", {o_acc_clr, o_done, o_err, o_row_edge_valid, o_col_edge_valid}, '0);
    tick();
    rst = 1'b0;
    tick();
    i_corner_done = 1'b1;
    go(3);
    wait_done("t6b_done", 50);
    chk("t6b_err", o_err, 1'b0);
    i_corner_done = 1'b0;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule

// File: doc/sys_arr_tile_ctrl.md
# sys_arr_tile_ctrl

Tile sequencer for the N×N FP32 multiply-accumulate systolic array. On `start` it clears the PE accumulators and streams exactly `k_len` operands into every west-edge row lane and north-edge column lane, with a one-cycle-per-lane skew. It then waits for the bottom-right PE to report `k_len` completed MACs and pulses `done` with a sticky overflow/underflow flag. Operand data travels directly from the edge buffers to the PEs; this block only drives the handshakes.

## Interface
- `N`, 4, array dimension (rows = columns), 2..16
- `KW`, 16, width of `k_len` and of all lane/done counters
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  begin a tile; sampled only in IDLE
- `abort`  in  1  synchronous abandon; returns to IDLE
- `k_len`  in  KW  operands per lane; captured on the accepted `start`
- `a_src_valid`  in  N  row buffer i holds an operand
- `a_src_pop`  out  N  row buffer i consumed this cycle
- `row_edge_valid`  out  N  to PE[i][0] `row_in_valid`
- `row_edge_ready`  in  N  from PE[i][0] `row_in_ready`
- `b_src_valid`, `b_src_pop`, `col_edge_valid`, `col_edge_ready`  same as the four row-lane ports, for column j into PE[0][j]
- `corner_done`  in  1  `comp_done` of PE[N-1][N-1]
- `pe_err`  in  N*N  `error_bit` of every PE
- `acc_clr`  out  1  accumulator clear pulse to all PEs
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle tile-complete pulse
- `err`  out  1  sticky OR of `pe_err` for the current tile

## Operation
- States: IDLE, CLEAR, FEED, DRAIN, DONE.
- IDLE:
  - When `start` is high, capture `k_len`, zero all lane counters, the skew counter, the done counter and `err`, then go to CLEAR.
  - `start` is ignored in every state except IDLE.
- CLEAR:
  - Lasts exactly one cycle with `acc_clr` = 1.
  - Go to FEED, or directly to DONE if the captured `k_len` = 0.
- FEED:
  - The skew counter starts at 0, increments once per cycle and saturates at N-1.
  - Lane i (row or column) is eligible when skew ≥ i and its lane count < `k_len`.
  - `row_edge_valid[i]` = eligible & `a_src_valid[i]`.
  - `a_src_pop[i]` = `row_edge_valid[i]` & `row_edge_ready[i]`. The lane counter increments on the same condition.
  - Column lanes behave identically.
  - Go to DRAIN when all 2N lane counters equal `k_len`.
- DRAIN:
  - All edge valids are 0.
  - Go to DONE when the done count ≥ `k_len`.
- DONE:
  - Lasts one cycle with `done` = 1, then go to IDLE.
- Done counter: increments on every `corner_done` pulse in FEED and DRAIN and saturates at 2^KW−1. Pulses are ignored in IDLE, CLEAR and DONE.
- `err`:
  - ORs in `|pe_err` every cycle in FEED and DRAIN.
  - Holds its value through DONE and IDLE until the next CLEAR.
- `abort` has priority over all other transitions. From any non-IDLE state it moves to IDLE on the next edge:
  - no `done` pulse
  - all valids and pops are 0 from that edge
  - counters are left as-is until the next `start`
- Reset: go to IDLE. All outputs reset to 0; all counters and the captured `k_len` reset to 0.

## Timing
- `start` at edge 0: CLEAR is active in cycle 1, FEED begins in cycle 2, and lane i can first be valid in cycle 2+i.
- Edge valid is a pure function of registered state and `*_src_valid`. It never depends combinationally on `*_edge_ready`.
- Pop and counter increment happen in the same cycle as the valid/ready handshake. A lane never issues more than `k_len` handshakes.
- When every lane's source and ready stay high throughout, FEED lasts `k_len`+N−1 cycles.
- DRAIN lasts at least one cycle, even if the done count already equals `k_len` on entry.
- `done` comes 1 cycle after the DRAIN exit condition. `busy` falls in the cycle after `done`. `err` is valid in the `done` cycle.
- `start` in the same cycle as `done`: ignored, because the state is DONE.
- `abort` and `start` in IDLE in the same cycle: `start` wins.
- Asserting `rst` mid-tile forces all outputs to 0 asynchronously.

## Test plan
- N=4, `k_len`=3, all sources and readies high:
  - `acc_clr` high in cycle 1.
  - `row_edge_valid[0]` high in cycles 2–4 and `row_edge_valid[3]` in cycles 5–7.
  - Exactly 3 pops per lane.
  - Drive `corner_done` 3 times → `done` 1 cycle after the 3rd count is observed in DRAIN, `err`=0.
- `k_len`=0 → CLEAR then DONE: `done` in cycle 2, no edge valid ever asserted.
- Random stalls on `row_edge_ready`/`col_edge_ready` and on the source valids, `k_len`=5 → every lane pops exactly 5, no pop without ready, FEED exits only after the slowest lane.
- Pulse `pe_err[7]` once in FEED → `err`=1 at `done`. The next tile with no errors → `err` cleared in CLEAR and 0 at `done`.
- `abort` in FEED after 2 handshakes → IDLE next cycle, valids drop, no `done`. A new `start` then runs a full tile correctly.
- Assert `rst` in DRAIN → all outputs 0 immediately and IDLE. `start` after release → normal tile.
